// File: rtl/frame_buf_ctl.sv
// frame_buf_ctl: triple-buffer frame scheduler for the camera DDR frame store.
//
// The writer side gets a free slot whenever capture_en is high and never
// stalls. The host side always receives the newest complete frame. A READY
// frame that nobody has read is recycled when a newer frame completes.
//
// Ports:
//   clk, reset_n        clock; synchronous active-low reset
//   capture_en          level, permits new frames to start
//   wr_start/addr/slot  writer slot assignment (pulse + held address/index)
//   wr_done, wr_abort   writer completion / discard pulses
//   rd_req, rd_ack      host request / consumed pulses
//   readout_start/addr/count/done  readout block control
//   rd_slot             slot index being read
//   frame_avail         a READY slot exists
//   frames_skipped      saturating count of overwritten unread frames
//
// Build option: FRAME_BUF_SKIP_CNT_EN enables the frames_skipped counter;
// when undefined, frames_skipped is tied to zero.

module frame_buf_ctl #(
   parameter logic [29:0] BASE_ADDR   = 30'h0000000,
   parameter logic [29:0] SLOT_BYTES  = 30'h0800000,
   parameter logic [23:0] FRAME_BYTES = 24'd5038848
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        capture_en,
   output logic        wr_start,
   output logic [29:0] wr_addr,
   input  logic        wr_done,
   input  logic        wr_abort,
   input  logic        rd_req,
   input  logic        rd_ack,
   output logic        readout_start,
   output logic [29:0] readout_addr,
   output logic [23:0] readout_count,
   output logic        readout_done,
   output logic        frame_avail,
   output logic [1:0]  wr_slot,
   output logic [1:0]  rd_slot,
   output logic [7:0]  frames_skipped
);

   localparam int unsigned NUM_SLOTS = 3;

   typedef enum logic [1:0] {S_FREE, S_WRITING, S_READY, S_READING} slot_st_t;
   typedef enum logic {W_IDLE, W_ACTIVE} w_st_t;
   typedef enum logic {R_IDLE, R_BUSY} r_st_t;

   slot_st_t    slot_q [NUM_SLOTS];
   slot_st_t    slot_d [NUM_SLOTS];
   w_st_t       w_q, w_d;
   r_st_t       r_q, r_d;
   logic        pend_q, pend_d;

   logic        wr_start_d, rd_start_d, rd_done_d, avail_d;
   logic [29:0] wr_addr_d, rd_addr_d;
   logic [23:0] rd_count_d;
   logic [1:0]  wr_slot_d, rd_slot_d;

   logic [1:0]  free_idx, ready_idx;
   logic        free_found, ready_any, ready_taken;
`ifdef FRAME_BUF_SKIP_CNT_EN
   logic        skip_evt;
`endif

   function automatic logic [29:0] slot_addr(input logic [1:0] idx);
      return BASE_ADDR + SLOT_BYTES * 30'(idx);
   endfunction

   // Next-state for slots, both FSMs and all registered outputs
   always_comb begin
      slot_d      = slot_q;
      w_d         = w_q;
      r_d         = r_q;
      pend_d      = pend_q;
      wr_start_d  = 1'b0;
      wr_addr_d   = wr_addr;
      wr_slot_d   = wr_slot;
      rd_start_d  = 1'b0;
      rd_done_d   = 1'b0;
      rd_addr_d   = readout_addr;
      rd_count_d  = readout_count;
      rd_slot_d   = rd_slot;
      avail_d     = 1'b0;
      free_idx    = 2'd0;
      free_found  = 1'b0;
      ready_idx   = 2'd0;
      ready_any   = 1'b0;
      ready_taken = 1'b0;
`ifdef FRAME_BUF_SKIP_CNT_EN
      skip_evt    = 1'b0;
`endif

      // Decisions use slot states as registered at the start of the cycle
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         if (!free_found && slot_q[i] == S_FREE) begin
            free_idx   = 2'(i);
            free_found = 1'b1;
         end
         if (slot_q[i] == S_READY) begin
            ready_idx = 2'(i);
            ready_any = 1'b1;
         end
      end

      case (r_q)
         R_IDLE: begin
            if ((rd_req || pend_q) && ready_any) begin
               slot_d[ready_idx] = S_READING;
               rd_addr_d         = slot_addr(ready_idx);
               rd_count_d        = FRAME_BYTES;
               rd_slot_d         = ready_idx;
               rd_start_d        = 1'b1;
               pend_d            = 1'b0;
               ready_taken       = 1'b1;
               r_d               = R_BUSY;
            end else if (rd_req) begin
               pend_d = 1'b1;
            end
         end
         R_BUSY: begin
            if (rd_req) pend_d = 1'b1;
            if (rd_ack) begin
               slot_d[rd_slot] = S_FREE;
               rd_done_d       = 1'b1;
               r_d             = R_IDLE;
            end
         end
         default: r_d = R_IDLE;
      endcase

      case (w_q)
         W_IDLE: begin
            if (capture_en) begin
               slot_d[free_idx] = S_WRITING;
               wr_addr_d        = slot_addr(free_idx);
               wr_slot_d        = free_idx;
               wr_start_d       = 1'b1;
               w_d              = W_ACTIVE;
            end
         end
         W_ACTIVE: begin
            if (wr_abort) begin
               slot_d[wr_slot] = S_FREE;
               w_d             = W_IDLE;
            end else if (wr_done) begin
               // An older READY frame not claimed by the reader this cycle is recycled
               if (ready_any && !ready_taken) begin
                  slot_d[ready_idx] = S_FREE;
`ifdef FRAME_BUF_SKIP_CNT_EN
                  skip_evt = 1'b1;
`endif
               end
               slot_d[wr_slot] = S_READY;
               w_d             = W_IDLE;
            end
         end
         default: w_d = W_IDLE;
      endcase

      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         if (slot_d[i] == S_READY) avail_d = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) slot_q[i] <= S_FREE;
         w_q           <= W_IDLE;
         r_q           <= R_IDLE;
         pend_q        <= 1'b0;
         wr_start      <= 1'b0;
         wr_addr       <= 30'd0;
         wr_slot       <= 2'd0;
         readout_start <= 1'b0;
         readout_done  <= 1'b0;
         readout_addr  <= 30'd0;
         readout_count <= 24'd0;
         rd_slot       <= 2'd0;
         frame_avail   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) slot_q[i] <= slot_d[i];
         w_q           <= w_d;
         r_q           <= r_d;
         pend_q        <= pend_d;
         wr_start      <= wr_start_d;
         wr_addr       <= wr_addr_d;
         wr_slot       <= wr_slot_d;
         readout_start <= rd_start_d;
         readout_done  <= rd_done_d;
         readout_addr  <= rd_addr_d;
         readout_count <= rd_count_d;
         rd_slot       <= rd_slot_d;
         frame_avail   <= avail_d;
      end
   end

`ifdef FRAME_BUF_SKIP_CNT_EN
   // Saturating skipped-frame counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frames_skipped <= 8'd0;
      end else if (skip_evt && frames_skipped != 8'hFF) begin
         frames_skipped <= frames_skipped + 8'd1;
      end
   end
`else
   assign frames_skipped = 8'd0;
`endif

endmodule

// File: tb/tb_frame_buf_ctl.sv
// Directed bench for frame_buf_ctl: reset, write/read handshakes, frame
// recycling, pending requests, abort, and reset during a readout.

module tb_frame_buf_ctl;

   logic        clk = 1'b0;
   logic        reset_n, capture_en, wr_done, wr_abort, rd_req, rd_ack;
   logic        wr_start, readout_start, readout_done, frame_avail;
   logic [29:0] wr_addr, readout_addr;
   logic [23:0] readout_count;
   logic [1:0]  wr_slot, rd_slot;
   logic [7:0]  frames_skipped;

   int checks = 0;
   int errors = 0;

`ifdef FRAME_BUF_SKIP_CNT_EN
   localparam logic [7:0] EXP_SKIP = 8'd2;
`else
   localparam logic [7:0] EXP_SKIP = 8'd0;
`endif

   frame_buf_ctl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .capture_en     (capture_en),
      .wr_start       (wr_start),
      .wr_addr        (wr_addr),
      .wr_done        (wr_done),
      .wr_abort       (wr_abort),
      .rd_req         (rd_req),
      .rd_ack         (rd_ack),
      .readout_start  (readout_start),
      .readout_addr   (readout_addr),
      .readout_count  (readout_count),
      .readout_done   (readout_done),
      .frame_avail    (frame_avail),
      .wr_slot        (wr_slot),
      .rd_slot        (rd_slot),
      .frames_skipped (frames_skipped)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete write: start, check address, then wr_done
   task automatic write_frame(input string tag, input logic [29:0] exp_addr, input logic [1:0] exp_slot);
      capture_en = 1'b1;
      tick();
      capture_en = 1'b0;
      chk({tag, "_wr_start"}, 32'(wr_start), 32'd1);
      chk({tag, "_wr_addr"},  32'(wr_addr),  32'(exp_addr));
      chk({tag, "_wr_slot"},  32'(wr_slot),  32'(exp_slot));
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; capture_en = 1'b0; wr_done = 1'b0; wr_abort = 1'b0;
      rd_req = 1'b0;  rd_ack = 1'b0;
      tick(); tick();
      chk("rst_wr_start", 32'(wr_start), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_rd_count", 32'(readout_count), 32'd0);
      chk("rst_avail", 32'(frame_avail), 32'd0);
      chk("rst_skip", 32'(frames_skipped), 32'd0);
      reset_n = 1'b1;

      // 1: first frame into slot 0
      capture_en = 1'b1;
      tick();
      capture_en = 1'b0;
      chk("s1_wr_start", 32'(wr_start), 32'd1);
      chk("s1_wr_addr", 32'(wr_addr), 32'h0000000);
      chk("s1_wr_slot", 32'(wr_slot), 32'd0);
      tick();
      chk("s1_wr_start_pulse", 32'(wr_start), 32'd0);
      chk("s1_avail_pre", 32'(frame_avail), 32'd0);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("s1_avail", 32'(frame_avail), 32'd1);

      // 2: read slot 0; rd_ack in idle earlier would be ignored
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("s2_rd_start", 32'(readout_start), 32'd1);
      chk("s2_rd_addr", 32'(readout_addr), 32'h0000000);
      chk("s2_rd_count", 32'(readout_count), 32'h4CE300);
      chk("s2_rd_slot", 32'(rd_slot), 32'd0);
      tick();
      chk("s2_rd_start_pulse", 32'(readout_start), 32'd0);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("s2_rd_done", 32'(readout_done), 32'd1);
      chk("s2_avail", 32'(frame_avail), 32'd0);
      tick();
      chk("s2_rd_done_pulse", 32'(readout_done), 32'd0);

      // 3: hold slot 0 in READING, then write three unread frames
      write_frame("s3a", 30'h0000000, 2'd0);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("s3_rd_start", 32'(readout_start), 32'd1);
      write_frame("s3b", 30'h0800000, 2'd1);
      write_frame("s3c", 30'h1000000, 2'd2);
      write_frame("s3d", 30'h0800000, 2'd1);
      chk("s3_skip", 32'(frames_skipped), 32'(EXP_SKIP));
      chk("s3_avail", 32'(frame_avail), 32'd1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("s3_rd_done", 32'(readout_done), 32'd1);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("s3_rd_start2", 32'(readout_start), 32'd1);
      chk("s3_rd_addr", 32'(readout_addr), 32'h0800000);
      chk("s3_rd_slot", 32'(rd_slot), 32'd1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("s3_avail_end", 32'(frame_avail), 32'd0);

      // 4: request with nothing READY stays pending until a frame lands
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("s4_no_start", 32'(readout_start), 32'd0);
      capture_en = 1'b1;
      tick();
      capture_en = 1'b0;
      chk("s4_wr_addr", 32'(wr_addr), 32'h0000000);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("s4_m1_no_start", 32'(readout_start), 32'd0);
      tick();
      chk("s4_m2_start", 32'(readout_start), 32'd1);
      chk("s4_rd_addr", 32'(readout_addr), 32'h0000000);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("s4_rd_done", 32'(readout_done), 32'd1);

      // 5: abort (and abort winning over a simultaneous done) frees slot 0
      capture_en = 1'b1;
      tick();
      capture_en = 1'b0;
      chk("s5_wr_addr", 32'(wr_addr), 32'h0000000);
      wr_done = 1'b1; wr_abort = 1'b1;
      tick();
      wr_done = 1'b0; wr_abort = 1'b0;
      chk("s5_avail", 32'(frame_avail), 32'd0);
      capture_en = 1'b1;
      tick();
      capture_en = 1'b0;
      chk("s5_restart", 32'(wr_start), 32'd1);
      chk("s5_reuse_addr", 32'(wr_addr), 32'h0000000);
      wr_abort = 1'b1;
      tick();
      wr_abort = 1'b0;
      chk("s5_avail2", 32'(frame_avail), 32'd0);

      // 6: reset during a readout with a write in flight
      write_frame("s6a", 30'h0000000, 2'd0);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("s6_rd_start", 32'(readout_start), 32'd1);
      capture_en = 1'b1;
      tick();
      capture_en = 1'b0;
      chk("s6_wr_addr", 32'(wr_addr), 32'h0800000);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("s6_wr_addr_rst", 32'(wr_addr), 32'd0);
      chk("s6_wr_slot_rst", 32'(wr_slot), 32'd0);
      chk("s6_rd_addr_rst", 32'(readout_addr), 32'd0);
      chk("s6_rd_count_rst", 32'(readout_count), 32'd0);
      chk("s6_rd_slot_rst", 32'(rd_slot), 32'd0);
      chk("s6_avail_rst", 32'(frame_avail), 32'd0);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("s6_no_done", 32'(readout_done), 32'd0);
      tick();
      chk("s6_no_done2", 32'(readout_done), 32'd0);
      chk("s6_skip", 32'(frames_skipped), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
